// File: rtl/pwm_breathe_multi.sv
// Multi-channel breathing PWM: triangle/sawtooth duty ramp with equally spaced channel phases.
// Optional square-law gamma on the duty when PWM_BREATHE_GAMMA_EN is defined.
module pwm_breathe_multi #(
  parameter int CH       = 4,
  parameter int PWM_W    = 8,
  parameter int PRESC    = 16,
  parameter int RAMP_DIV = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          mode,
  output logic [CH-1:0] pwm_out,
  output logic          period_stb
);

  localparam int RW  = PWM_W + 1;
  localparam int OFS = (2 ** RW) / CH;
  localparam int PW  = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int RDW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_MAX = PW'(PRESC - 1);
  localparam logic [RDW-1:0] RDIV_MAX  = RDW'(RAMP_DIV - 1);

  logic [PW-1:0]    presc_cnt;
  logic [PWM_W-1:0] pwm_cnt;
  logic [RW-1:0]    ramp;
  logic [RDW-1:0]   ramp_div_cnt;
  logic [PWM_W-1:0] duty_lat [CH];
  logic [PWM_W-1:0] duty_nxt [CH];
  logic [RW-1:0]    ph       [CH];
  logic [CH-1:0]    cmp;
  logic             tick;
  logic             wrap;

  // Square-law perceptual correction; identity in the linear build.
  function automatic logic [PWM_W-1:0] gamma(input logic [PWM_W-1:0] d);
`ifdef PWM_BREATHE_GAMMA_EN
    logic [2*PWM_W-1:0] sq;
    sq = {{PWM_W{1'b0}}, d} * {{PWM_W{1'b0}}, d};
    return sq[2*PWM_W-1:PWM_W];
`else
    return d;
`endif
  endfunction

  function automatic logic [PWM_W-1:0] duty_map(input logic m, input logic [RW-1:0] p);
    if (m || !p[PWM_W]) return p[PWM_W-1:0];
    return ~p[PWM_W-1:0];
  endfunction

  assign tick = en && (presc_cnt == PRESC_MAX);
  assign wrap = tick && (&pwm_cnt);

  // Stage 0: next-period duty from the current ramp, plus per-channel compare
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      ph[i]       = ramp + RW'(i * OFS);
      duty_nxt[i] = gamma(duty_map(mode, ph[i]));
      cmp[i]      = pwm_cnt < duty_lat[i];
    end
  end

  // Stage 1: counters, duty latch at period boundary, registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt    <= '0;
      pwm_cnt      <= '0;
      ramp         <= '0;
      ramp_div_cnt <= '0;
      pwm_out      <= '0;
      period_stb   <= 1'b0;
      for (int i = 0; i < CH; i++) duty_lat[i] <= '0;
    end else begin
      pwm_out    <= en ? cmp : '0;
      period_stb <= wrap;
      if (en) presc_cnt <= (presc_cnt == PRESC_MAX) ? '0 : presc_cnt + PW'(1);
      if (tick) pwm_cnt <= pwm_cnt + PWM_W'(1);
      if (wrap) begin
        duty_lat <= duty_nxt;
        if (ramp_div_cnt == RDIV_MAX) begin
          ramp_div_cnt <= '0;
          ramp         <= ramp + RW'(1);
        end else begin
          ramp_div_cnt <= ramp_div_cnt + RDW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_breathe_multi.sv
// Directed bench for pwm_breathe_multi: reset, triangle/sawtooth ramps, en gating, async reset,
// and a second single-channel PRESC=1 instance for the gamma/linear duty map.
module tb_pwm_breathe_multi;
  localparam int PWM_W = 4, CH = 2, PRESC = 2, RAMP_DIV = 1;

  logic          clk = 1'b0;
  logic          rst_n, en, mode;
  logic [CH-1:0] pwm_out;
  logic          period_stb;
  logic          rst_ng, en_g, mode_g;
  logic [0:0]    pwm_g;
  logic          stb_g;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pwm_breathe_multi #(.CH(CH), .PWM_W(PWM_W), .PRESC(PRESC), .RAMP_DIV(RAMP_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .pwm_out(pwm_out), .period_stb(period_stb)
  );

  pwm_breathe_multi #(.CH(1), .PWM_W(4), .PRESC(1), .RAMP_DIV(1)) dut_g (
    .clk(clk), .rst_n(rst_ng), .en(en_g), .mode(mode_g), .pwm_out(pwm_g), .period_stb(stb_g)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int gam(input int d);
`ifdef PWM_BREATHE_GAMMA_EN
    return (d * d) >> 4;
`else
    return d;
`endif
  endfunction

  // Reference duty for a 5-bit phase: triangle mirrors at 16, sawtooth is the low nibble.
  function automatic int ref_duty(input logic m, input int ph);
    int p;
    p = ph % 32;
    if (m) return p % 16;
    return (p >= 16) ? (31 - p) : p;
  endfunction

  // Count high samples per channel up to and including the period_stb sample.
  task automatic run_period(input int drop_at, input int off_len,
                            output int hi0, output int hi1, output int clks);
    hi0 = 0; hi1 = 0; clks = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      clks = n;
      hi0 += int'(pwm_out[0]);
      hi1 += int'(pwm_out[1]);
      if (drop_at >= 0 && n > drop_at && n <= drop_at + off_len)
        chk($sformatf("gate_low_n%0d", n), int'(pwm_out), 0);
      if (period_stb) return;
      if (n == drop_at) en = 1'b0;
      if (n == drop_at + off_len) en = 1'b1;
    end
    chk("stb_timeout", int'(period_stb), 1);
  endtask

  task automatic period_chk(input string tag, input int r, input logic m, input int drop_at);
    int h0, h1, c;
    run_period(drop_at, 10, h0, h1, c);
    chk({tag, "_clks"}, c, (drop_at >= 0) ? 42 : 32);
    chk({tag, "_ch0"}, h0, 2 * gam(ref_duty(m, r)));
    chk({tag, "_ch1"}, h1, 2 * gam(ref_duty(m, r + 16)));
  endtask

  task automatic run_period_g(output int hi, output int clks);
    hi = 0; clks = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      clks = n;
      hi += int'(pwm_g[0]);
      if (stb_g) return;
    end
    chk("stb_g_timeout", int'(stb_g), 1);
  endtask

  initial begin
    int h0, h1, c;
    rst_n = 1'b0; en = 1'b1; mode = 1'b0;
    rst_ng = 1'b0; en_g = 1'b0; mode_g = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_stb", int'(period_stb), 0);
    rst_n = 1'b1;

    // First period after reset: duty_lat is zero, wrap 32 clocks after release
    run_period(-1, 0, h0, h1, c);
    chk("p1_clks", c, 32);
    chk("p1_ch0", h0, 0);
    chk("p1_ch1", h1, 0);

    // Triangle offsets: ramp 0 -> ch0 0 / ch1 15, ramp 1 -> ch0 1 / ch1 14
    run_period(-1, 0, h0, h1, c);
    chk("p2_ch0", h0, 2 * gam(0));
    chk("p2_ch1", h1, 2 * gam(15));
    run_period(-1, 0, h0, h1, c);
    chk("p3_ch0", h0, 2 * gam(1));
    chk("p3_ch1", h1, 2 * gam(14));

    // Full triangle sweep through ramp wrap 31 -> 0; en dropped 10 clks mid-period at ramp 8
    for (int r = 2; r <= 32; r++)
      period_chk($sformatf("tri_r%0d", r), r, 1'b0, (r == 8) ? 9 : -1);

    // Sawtooth: mode change lands one period later; ch0 steps 15 -> 0 at ramp 15 -> 16
    mode = 1'b1;
    for (int r = 33; r <= 49; r++)
      period_chk($sformatf("saw_r%0d", r), r, (r == 33) ? 1'b0 : 1'b1, -1);

    // Async reset pulse between clock edges
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pwm", int'(pwm_out), 0);
    chk("arst_stb", int'(period_stb), 0);
    #1 rst_n = 1'b1;
    mode = 1'b0;
    @(negedge clk);
    run_period(-1, 0, h0, h1, c);
    chk("arst_p1_clks", c, 32);
    chk("arst_p1_ch0", h0, 0);
    chk("arst_p1_ch1", h1, 0);
    run_period(-1, 0, h0, h1, c);
    chk("arst_p2_ch0", h0, 0);
    chk("arst_p2_ch1", h1, 2 * gam(15));

    // Single channel, PRESC=1, sawtooth: duty equals ramp (gamma: 15->14, 8->4, 3->0)
    en_g = 1'b1;
    @(negedge clk);
    rst_ng = 1'b1;
    run_period_g(h0, c);
    chk("g_p1_clks", c, 16);
    chk("g_p1_hi", h0, 0);
    for (int r = 0; r <= 15; r++) begin
      run_period_g(h0, c);
      chk($sformatf("g_r%0d_hi", r), h0, gam(r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
